alu_cmd_seq: RTL and testbench

//  Command initiator for the top ALU datapath (cmdin/din_1..3 -> dout_high/dout_low/zero/error).

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_cmd_seq.sv | 171 +++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the top ALU and its command sequencer.
// The ALU command word is {a_sel[1:0], b_sel[1:0], op[1:0]}.
package alu_pkg;

    localparam int CMD_W = 6;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } alu_op_e;

    // SEL_ILL is never driven onto cmdin; a request naming it is answered with an error.
    typedef enum logic [1:0] {
        SEL_D1  = 2'd0,
        SEL_D2  = 2'd1,
        SEL_D3  = 2'd2,
        SEL_ILL = 2'd3
    } alu_sel_e;

    // Sequencer states, exported so checkers can observe them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    function automatic logic [CMD_W-1:0] pack_cmd(input alu_sel_e a_sel,
                                                  input alu_sel_e b_sel,
                                                  input alu_op_e  op);
        return {a_sel, b_sel, op};
    endfunction

endpackage

// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: turns request transactions into ALU command/operand drives, waits out the
// ALU latency, captures the result and hands it back as a response transaction.
// Build option: define ALU_CMD_SEQ_STATS_EN to add the stat_ops/stat_errs counters.
// Handshake rule (both channels): a transfer happens on a rising clk edge where valid and
// ready are both high; the valid side holds its payload stable until that edge.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 2   // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [1:0]       req_a_sel,
    input  logic [1:0]       req_b_sel,
    input  logic [WIDTH-1:0] req_d1,
    input  logic [WIDTH-1:0] req_d2,
    input  logic [WIDTH-1:0] req_d3,
    output logic [CMD_W-1:0] cmdin,
    output logic [WIDTH-1:0] din_1,
    output logic [WIDTH-1:0] din_2,
    output logic [WIDTH-1:0] din_3,
    input  logic [WIDTH-1:0] alu_dout_high,
    input  logic [WIDTH-1:0] alu_dout_low,
    input  logic             alu_zero,
    input  logic             alu_error,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_high,
    output logic [WIDTH-1:0] rsp_low,
    output logic             rsp_zero,
    output logic             rsp_error,
    output logic [1:0]       dbg_state
`ifdef ALU_CMD_SEQ_STATS_EN
    ,
    output logic [15:0]      stat_ops,
    output logic [15:0]      stat_errs
`endif
);

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    seq_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CMD_W-1:0] cmdin_q, cmdin_d;
    logic [WIDTH-1:0] din1_q, din1_d, din2_q, din2_d, din3_q, din3_d;
    logic [WIDTH-1:0] rsp_high_q, rsp_high_d, rsp_low_q, rsp_low_d;
    logic             rsp_zero_q, rsp_zero_d, rsp_error_q, rsp_error_d;

    // Next-state logic: accept in IDLE, count down the ALU latency in WAIT, hold in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmdin_d     = cmdin_q;
        din1_d      = din1_q;
        din2_d      = din2_q;
        din3_d      = din3_q;
        rsp_high_d  = rsp_high_q;
        rsp_low_d   = rsp_low_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_error_d = rsp_error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if ((req_a_sel == SEL_ILL) || (req_b_sel == SEL_ILL)) begin
                        // ALU inputs untouched so it never sees an illegal command.
                        rsp_high_d  = '0;
                        rsp_low_d   = '0;
                        rsp_zero_d  = 1'b0;
                        rsp_error_d = 1'b1;
                        state_d     = ST_RESP;
                    end else begin
                        cmdin_d = pack_cmd(alu_sel_e'(req_a_sel), alu_sel_e'(req_b_sel),
                                           alu_op_e'(req_op));
                        din1_d  = req_d1;
                        din2_d  = req_d2;
                        din3_d  = req_d3;
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_high_d  = alu_dout_high;
                    rsp_low_d   = alu_dout_low;
                    rsp_zero_d  = alu_zero;
                    rsp_error_d = alu_error;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // No accept here: IDLE always costs one bubble cycle between ops.
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmdin_q     <= '0;
            din1_q      <= '0;
            din2_q      <= '0;
            din3_q      <= '0;
            rsp_high_q  <= '0;
            rsp_low_q   <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmdin_q     <= cmdin_d;
            din1_q      <= din1_d;
            din2_q      <= din2_d;
            din3_q      <= din3_d;
            rsp_high_q  <= rsp_high_d;
            rsp_low_q   <= rsp_low_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign cmdin     = cmdin_q;
    assign din_1     = din1_q;
    assign din_2     = din2_q;
    assign din_3     = din3_q;
    assign rsp_high  = rsp_high_q;
    assign rsp_low   = rsp_low_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_error = rsp_error_q;
    assign dbg_state = state_q;

`ifdef ALU_CMD_SEQ_STATS_EN
    logic [15:0] stat_ops_q, stat_errs_q;
    logic        rsp_hs;

    assign rsp_hs = rsp_valid && rsp_ready;

    // Saturating counters of delivered responses and of error responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q  <= '0;
            stat_errs_q <= '0;
        end else if (rsp_hs) begin
            if (stat_ops_q != 16'hFFFF) begin
                stat_ops_q <= stat_ops_q + 16'd1;
            end
            if (rsp_error_q && (stat_errs_q != 16'hFFFF)) begin
                stat_errs_q <= stat_errs_q + 16'd1;
            end
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_errs = stat_errs_q;
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// tb_alu_cmd_seq: directed bench for alu_cmd_seq with a small behavioural ALU attached.
// The ALU model has ALU_LAT-1 register stages, so its outputs are valid exactly when the
// sequencer is due to capture them.
module tb_alu_cmd_seq;

    localparam int W       = 8;
    localparam int ALU_LAT = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [1:0]   req_op, req_a_sel, req_b_sel;
    logic [W-1:0] req_d1, req_d2, req_d3;
    logic [5:0]   cmdin;
    logic [W-1:0] din_1, din_2, din_3;
    logic [W-1:0] alu_dout_high, alu_dout_low;
    logic         alu_zero, alu_error;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_high, rsp_low;
    logic         rsp_zero, rsp_error;
    logic [1:0]   dbg_state;
`ifdef ALU_CMD_SEQ_STATS_EN
    logic [15:0]  stat_ops, stat_errs;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    alu_cmd_seq #(.WIDTH(W), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a_sel(req_a_sel), .req_b_sel(req_b_sel),
        .req_d1(req_d1), .req_d2(req_d2), .req_d3(req_d3),
        .cmdin(cmdin), .din_1(din_1), .din_2(din_2), .din_3(din_3),
        .alu_dout_high(alu_dout_high), .alu_dout_low(alu_dout_low),
        .alu_zero(alu_zero), .alu_error(alu_error),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_high(rsp_high), .rsp_low(rsp_low),
        .rsp_zero(rsp_zero), .rsp_error(rsp_error),
        .dbg_state(dbg_state)
`ifdef ALU_CMD_SEQ_STATS_EN
        , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural ALU: high/low halves of the 2W-bit result; div gives {rem, quot}.
    logic [W-1:0]   ma, mb;
    logic [2*W-1:0] mr;
    logic           merr;

    function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] x1,
                                          input logic [W-1:0] x2, input logic [W-1:0] x3);
        case (s)
            2'd0:    return x1;
            2'd1:    return x2;
            2'd2:    return x3;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        ma   = pick(cmdin[5:4], din_1, din_2, din_3);
        mb   = pick(cmdin[3:2], din_1, din_2, din_3);
        mr   = '0;
        merr = 1'b0;
        case (cmdin[1:0])
            2'd0: mr = (2*W)'(ma) + (2*W)'(mb);
            2'd1: mr = (2*W)'(ma) - (2*W)'(mb);
            2'd2: mr = (2*W)'(ma) * (2*W)'(mb);
            default: begin
                if (mb == '0) merr = 1'b1;
                else          mr = {ma % mb, ma / mb};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        alu_dout_high <= mr[2*W-1:W];
        alu_dout_low  <= mr[W-1:0];
        alu_zero      <= !merr && (mr == '0);
        alu_error     <= merr;
    end

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Driver: present a request, wait for acceptance, then scramble req_* to show they are ignored.
    task automatic send_req(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                            input logic [W-1:0] d1, input logic [W-1:0] d2, input logic [W-1:0] d3);
        int guard = 0;
        req_op = op; req_a_sel = a; req_b_sel = b;
        req_d1 = d1; req_d2 = d2; req_d3 = d3;
        req_valid = 1'b1;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        check("accept_timeout", 32'(guard < 20), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom_range(0, 3));
        req_a_sel = 2'($urandom_range(0, 3));
        req_b_sel = 2'($urandom_range(0, 3));
        req_d1    = W'($urandom_range(0, 255));
        req_d2    = W'($urandom_range(0, 255));
        req_d3    = W'($urandom_range(0, 255));
    endtask

    // Count cycles from the accept edge until rsp_valid is seen (bounded).
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    // Complete the response handshake and return to IDLE.
    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_hs_req_ready", 32'(req_ready), 32'd1);
    endtask

    int lat;
    int bad;

    initial begin
        // Reset
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a_sel = '0; req_b_sel = '0;
        req_d1 = '0; req_d2 = '0; req_d3 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_cmdin",     32'(cmdin),     32'd0);
        check("rst_din_1",     32'(din_1),     32'd0);
        check("rst_rsp_low",   32'(rsp_low),   32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_state",     32'(dbg_state), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Add: 3 + 4 on din_1/din_2
        send_req(2'd0, 2'd0, 2'd1, 8'd3, 8'd4, 8'd9);
        check("add_state_wait", 32'(dbg_state), 32'd1);
        check("add_req_ready",  32'(req_ready), 32'd0);
        wait_rsp(lat);
        check("add_latency",  32'(lat),       32'(ALU_LAT + 1));
        check("add_cmdin",    32'(cmdin),     32'd4);
        check("add_din_1",    32'(din_1),     32'd3);
        check("add_din_2",    32'(din_2),     32'd4);
        check("add_rsp_low",  32'(rsp_low),   32'd7);
        check("add_rsp_high", 32'(rsp_high),  32'd0);
        check("add_rsp_zero", 32'(rsp_zero),  32'd0);
        check("add_rsp_err",  32'(rsp_error), 32'd0);
        take_rsp();

        // Mul overflow: 80 * 5 = 400 = 0x190
        send_req(2'd2, 2'd0, 2'd1, 8'd80, 8'd5, 8'd0);
        wait_rsp(lat);
        check("mul_latency",  32'(lat),      32'(ALU_LAT + 1));
        check("mul_cmdin",    32'(cmdin),    32'd6);
        check("mul_rsp_high", 32'(rsp_high), 32'd1);
        check("mul_rsp_low",  32'(rsp_low),  32'h90);
        take_rsp();

        // Div by zero: 20 / din_3(=0)
        send_req(2'd3, 2'd0, 2'd2, 8'd20, 8'd7, 8'd0);
        wait_rsp(lat);
        check("div0_cmdin",   32'(cmdin),     32'd11);
        check("div0_rsp_err", 32'(rsp_error), 32'd1);
        take_rsp();

        // Sub to zero: din_2 - din_3 = 9 - 9
        send_req(2'd1, 2'd1, 2'd2, 8'd1, 8'd9, 8'd9);
        wait_rsp(lat);
        check("sub_cmdin",    32'(cmdin),     32'd25);
        check("sub_rsp_low",  32'(rsp_low),   32'd0);
        check("sub_rsp_zero", 32'(rsp_zero),  32'd1);
        check("sub_rsp_err",  32'(rsp_error), 32'd0);
        take_rsp();

        // Illegal select: straight to RESP, ALU inputs untouched
        send_req(2'd0, 2'd3, 2'd0, 8'd50, 8'd60, 8'd70);
        wait_rsp(lat);
        check("ill_latency",  32'(lat),       32'd1);
        check("ill_rsp_err",  32'(rsp_error), 32'd1);
        check("ill_rsp_high", 32'(rsp_high),  32'd0);
        check("ill_rsp_low",  32'(rsp_low),   32'd0);
        check("ill_rsp_zero", 32'(rsp_zero),  32'd0);
        check("ill_cmdin",    32'(cmdin),     32'd25);
        check("ill_din_2",    32'(din_2),     32'd9);
        take_rsp();

        // Backpressure: 100 + 200 = 300 = 0x12C, held for 5 cycles with a request pending
        send_req(2'd0, 2'd0, 2'd1, 8'd100, 8'd200, 8'd1);
        wait_rsp(lat);
        check("bp_latency", 32'(lat), 32'(ALU_LAT + 1));
        req_op = 2'd1; req_a_sel = 2'd2; req_b_sel = 2'd0;
        req_d1 = 8'd100; req_d2 = 8'd0; req_d3 = 8'd1;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_high",  32'(rsp_high),  32'd1);
            check("bp_rsp_low",   32'(rsp_low),   32'h2C);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp_hs_req_ready", 32'(req_ready), 32'd1);
        check("bp_hs_state",     32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("bp2_accepted", 32'(dbg_state), 32'd1);
        wait_rsp(lat);
        // din_3 - din_1 = 1 - 100 = -99 -> 0xFF9D
        check("bp2_latency",  32'(lat),      32'(ALU_LAT + 1));
        check("bp2_cmdin",    32'(cmdin),    32'd33);
        check("bp2_rsp_high", 32'(rsp_high), 32'hFF);
        check("bp2_rsp_low",  32'(rsp_low),  32'h9D);
        take_rsp();

        // Reset while waiting on the ALU
        send_req(2'd0, 2'd0, 2'd1, 8'd1, 8'd1, 8'd0);
        check("rw_state_wait", 32'(dbg_state), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rw_req_ready", 32'(req_ready), 32'd1);
        check("rw_cmdin",     32'(cmdin),     32'd0);
        check("rw_state",     32'(dbg_state), 32'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid) bad++;
            @(posedge clk); #1;
        end
        check("rw_no_rsp", 32'(bad), 32'd0);

        // Recovery after reset: din_2 * din_2 = 12 * 12 = 144
        send_req(2'd2, 2'd1, 2'd1, 8'd0, 8'd12, 8'd0);
        wait_rsp(lat);
        check("rec_cmdin",    32'(cmdin),    32'd22);
        check("rec_rsp_high", 32'(rsp_high), 32'd0);
        check("rec_rsp_low",  32'(rsp_low),  32'h90);
        take_rsp();

        // Report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
